// File: rtl/memory_access_sequencer_pkg.sv
// Shared encodings for the memory access sequencer: access sizes, operation codes
// (common with the arbiter) and the sequencer state encoding.
package memory_access_sequencer_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIRST_REQ,
        ST_FIRST_RELEASE,
        ST_SECOND_REQ,
        ST_SECOND_RELEASE,
        ST_DONE
    } state_t;

    // The reserved size encoding behaves as a full word.
    function automatic int access_bytes(input logic [1:0] size, input int word_bytes);
        case (size)
            SIZE_BYTE: return 1;
            SIZE_HALF: return 2;
            default:   return word_bytes;
        endcase
    endfunction

endpackage

// File: rtl/memory_access_sequencer_lane_aligner.sv
// Places an access of 1/2/full-word bytes at a byte offset across two adjacent words:
// the low half of the wide mask/data targets word W, the high half targets W+1.
module memory_access_sequencer_lane_aligner
    import memory_access_sequencer_pkg::*;
#(
    parameter int SIZE = 32,
    localparam int SIZE_BYTES = SIZE / 8,
    localparam int OFFSET_SIZE = $clog2(SIZE_BYTES)
) (
    input  logic [OFFSET_SIZE-1:0]  offset,
    input  logic [1:0]              size,
    input  logic [SIZE-1:0]         data,
    output logic [2*SIZE_BYTES-1:0] wide_mask,
    output logic [2*SIZE-1:0]       wide_data,
    output logic                    split
);

    logic [2*SIZE_BYTES-1:0] base_mask;

    always_comb begin
        base_mask = '0;
        for (int b = 0; b < SIZE_BYTES; b++) begin
            if (b < access_bytes(size, SIZE_BYTES)) begin
                base_mask[b] = 1'b1;
            end
        end
        wide_mask = base_mask << offset;
        wide_data = {{SIZE{1'b0}}, data} << (8 * offset);
        split     = |wide_mask[2*SIZE_BYTES-1:SIZE_BYTES];
    end

endmodule

// File: rtl/memory_access_sequencer.sv
// Turns byte-addressed load/store requests into one or two word transactions on an
// arbiter accessor slot, merging and extending read data on the way back.
module memory_access_sequencer
    import memory_access_sequencer_pkg::*;
#(
    parameter int SIZE = 32,
    parameter bit ALLOW_MISALIGNED = 1'b1,
    localparam int SIZE_BYTES = SIZE / 8,
    localparam int OFFSET_SIZE = $clog2(SIZE_BYTES),
    localparam int WORD_ADDRESS_SIZE = SIZE - OFFSET_SIZE
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         request_enable,
    input  logic                         request_operation,
    input  logic [1:0]                   request_size,
    input  logic                         request_signed,
    input  logic [SIZE-1:0]              request_address,
    input  logic [SIZE-1:0]              request_data_out,
    output logic                         request_ready,
    output logic                         request_error,
    output logic [SIZE-1:0]              request_data_in,
    output logic                         memory_enable,
    output logic                         memory_operation,
    input  logic                         memory_ready,
    output logic [SIZE_BYTES-1:0]        memory_byte_mask,
    output logic [WORD_ADDRESS_SIZE-1:0] memory_word_address,
    input  logic [SIZE-1:0]              memory_data_in,
    output logic [SIZE-1:0]              memory_data_out
);

    state_t                       state_q, state_d;
    logic                         operation_q, operation_d;
    logic [1:0]                   size_q, size_d;
    logic                         signed_q, signed_d;
    logic [SIZE-1:0]              address_q, address_d;
    logic [SIZE-1:0]              data_q, data_d;
    logic [SIZE-1:0]              first_q, first_d;
    logic [SIZE-1:0]              second_q, second_d;
    logic                         request_ready_q, request_ready_d;
    logic                         request_error_q, request_error_d;
    logic [SIZE-1:0]              request_data_in_q, request_data_in_d;
    logic                         memory_enable_q, memory_enable_d;
    logic                         memory_operation_q, memory_operation_d;
    logic [SIZE_BYTES-1:0]        memory_byte_mask_q, memory_byte_mask_d;
    logic [WORD_ADDRESS_SIZE-1:0] memory_word_address_q, memory_word_address_d;
    logic [SIZE-1:0]              memory_data_out_q, memory_data_out_d;

    logic [OFFSET_SIZE-1:0]       align_offset;
    logic [1:0]                   align_size;
    logic [SIZE-1:0]              align_data;
    logic [WORD_ADDRESS_SIZE-1:0] word_base;
    logic [2*SIZE_BYTES-1:0]      wide_mask;
    logic [2*SIZE-1:0]            wide_data;
    logic                         split;

    logic [2*SIZE-1:0]            merged_wide;
    logic [SIZE-1:0]              keep;
    logic                         sign_bit;
    logic [SIZE-1:0]              read_result;
    logic [SIZE-1:0]              final_data;

    // In IDLE the aligner looks at the live request so the accept decision needs no extra cycle.
    assign align_offset = (state_q == ST_IDLE) ? request_address[OFFSET_SIZE-1:0] : address_q[OFFSET_SIZE-1:0];
    assign align_size   = (state_q == ST_IDLE) ? request_size : size_q;
    assign align_data   = (state_q == ST_IDLE) ? request_data_out : data_q;
    assign word_base    = (state_q == ST_IDLE) ? request_address[SIZE-1:OFFSET_SIZE] : address_q[SIZE-1:OFFSET_SIZE];

    memory_access_sequencer_lane_aligner #(.SIZE(SIZE)) u_lane_aligner (
        .offset    (align_offset),
        .size      (align_size),
        .data      (align_data),
        .wide_mask (wide_mask),
        .wide_data (wide_data),
        .split     (split)
    );

    // Read merge is the inverse of the aligner: shift the word pair down, keep the access bytes, extend.
    always_comb begin
        merged_wide = {second_q, first_q} >> (8 * address_q[OFFSET_SIZE-1:0]);
        keep = '0;
        for (int b = 0; b < SIZE_BYTES; b++) begin
            if (b < access_bytes(size_q, SIZE_BYTES)) begin
                keep[8*b +: 8] = 8'hFF;
            end
        end
        case (size_q)
            SIZE_BYTE: sign_bit = merged_wide[7];
            SIZE_HALF: sign_bit = merged_wide[15];
            default:   sign_bit = merged_wide[SIZE-1];
        endcase
        read_result = (merged_wide[SIZE-1:0] & keep) | (~keep & {SIZE{signed_q & sign_bit}});
        final_data  = (operation_q == OP_READ) ? read_result : '0;
    end

    always_comb begin
        // NOTE: every _d starts as its _q so paths that do not assign it hold state instead of inferring a latch.
        state_d               = state_q;
        operation_d           = operation_q;
        size_d                = size_q;
        signed_d              = signed_q;
        address_d             = address_q;
        data_d                = data_q;
        first_d               = first_q;
        second_d              = second_q;
        request_ready_d       = request_ready_q;
        request_error_d       = request_error_q;
        request_data_in_d     = request_data_in_q;
        memory_enable_d       = memory_enable_q;
        memory_operation_d    = memory_operation_q;
        memory_byte_mask_d    = memory_byte_mask_q;
        memory_word_address_d = memory_word_address_q;
        memory_data_out_d     = memory_data_out_q;

        case (state_q)
            ST_IDLE: begin
                if (request_enable) begin
                    operation_d = request_operation;
                    size_d      = request_size;
                    signed_d    = request_signed;
                    address_d   = request_address;
                    data_d      = request_data_out;
                    first_d     = '0;
                    second_d    = '0;
                    if (split && !ALLOW_MISALIGNED) begin
                        state_d           = ST_DONE;
                        request_ready_d   = 1'b1;
                        request_error_d   = 1'b1;
                        request_data_in_d = '0;
                    end else begin
                        state_d               = ST_FIRST_REQ;
                        memory_enable_d       = 1'b1;
                        memory_operation_d    = request_operation;
                        memory_byte_mask_d    = wide_mask[SIZE_BYTES-1:0];
                        memory_word_address_d = word_base;
                        memory_data_out_d     = wide_data[SIZE-1:0];
                    end
                end
            end
            ST_FIRST_REQ: begin
                if (memory_ready) begin
                    first_d         = memory_data_in;
                    memory_enable_d = 1'b0;
                    state_d         = ST_FIRST_RELEASE;
                end
            end
            ST_FIRST_RELEASE: begin
                if (!memory_ready) begin
                    if (split) begin
                        state_d               = ST_SECOND_REQ;
                        memory_enable_d       = 1'b1;
                        memory_byte_mask_d    = wide_mask[2*SIZE_BYTES-1:SIZE_BYTES];
                        memory_word_address_d = word_base + 1'b1;
                        memory_data_out_d     = wide_data[2*SIZE-1:SIZE];
                    end else begin
                        state_d           = ST_DONE;
                        request_ready_d   = 1'b1;
                        request_error_d   = 1'b0;
                        request_data_in_d = final_data;
                    end
                end
            end
            ST_SECOND_REQ: begin
                if (memory_ready) begin
                    second_d        = memory_data_in;
                    memory_enable_d = 1'b0;
                    state_d         = ST_SECOND_RELEASE;
                end
            end
            ST_SECOND_RELEASE: begin
                if (!memory_ready) begin
                    state_d           = ST_DONE;
                    request_ready_d   = 1'b1;
                    request_error_d   = 1'b0;
                    request_data_in_d = final_data;
                end
            end
            ST_DONE: begin
                if (!request_enable) begin
                    state_d         = ST_IDLE;
                    request_ready_d = 1'b0;
                    request_error_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the asynchronous reset drops memory_enable at once; the arbiter then sees a normal release.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q               <= ST_IDLE;
            operation_q           <= 1'b0;
            size_q                <= 2'd0;
            signed_q              <= 1'b0;
            address_q             <= '0;
            data_q                <= '0;
            first_q               <= '0;
            second_q              <= '0;
            request_ready_q       <= 1'b0;
            request_error_q       <= 1'b0;
            request_data_in_q     <= '0;
            memory_enable_q       <= 1'b0;
            memory_operation_q    <= 1'b0;
            memory_byte_mask_q    <= '0;
            memory_word_address_q <= '0;
            memory_data_out_q     <= '0;
        end else begin
            state_q               <= state_d;
            operation_q           <= operation_d;
            size_q                <= size_d;
            signed_q              <= signed_d;
            address_q             <= address_d;
            data_q                <= data_d;
            first_q               <= first_d;
            second_q              <= second_d;
            request_ready_q       <= request_ready_d;
            request_error_q       <= request_error_d;
            request_data_in_q     <= request_data_in_d;
            memory_enable_q       <= memory_enable_d;
            memory_operation_q    <= memory_operation_d;
            memory_byte_mask_q    <= memory_byte_mask_d;
            memory_word_address_q <= memory_word_address_d;
            memory_data_out_q     <= memory_data_out_d;
        end
    end

    assign request_ready       = request_ready_q;
    assign request_error       = request_error_q;
    assign request_data_in     = request_data_in_q;
    assign memory_enable       = memory_enable_q;
    assign memory_operation    = memory_operation_q;
    assign memory_byte_mask    = memory_byte_mask_q;
    assign memory_word_address = memory_word_address_q;
    assign memory_data_out     = memory_data_out_q;

endmodule

// File: tb/tb_memory_access_sequencer.sv
// Directed-vector bench for memory_access_sequencer with a randomised-latency memory responder
// and a second instance built with misaligned accesses rejected.
module tb_memory_access_sequencer;
    import memory_access_sequencer_pkg::*;

    localparam int SIZE = 32;
    localparam int SB   = 4;
    localparam int WAS  = 30;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            request_enable = 1'b0;
    logic            request_operation = 1'b0;
    logic [1:0]      request_size = 2'd0;
    logic            request_signed = 1'b0;
    logic [SIZE-1:0] request_address = '0;
    logic [SIZE-1:0] request_data_out = '0;
    logic            request_ready;
    logic            request_error;
    logic [SIZE-1:0] request_data_in;
    logic            memory_enable;
    logic            memory_operation;
    logic            memory_ready = 1'b0;
    logic [SB-1:0]   memory_byte_mask;
    logic [WAS-1:0]  memory_word_address;
    logic [SIZE-1:0] memory_data_in = '0;
    logic [SIZE-1:0] memory_data_out;

    logic            nm_request_enable = 1'b0;
    logic            nm_request_ready;
    logic            nm_request_error;
    logic [SIZE-1:0] nm_request_data_in;
    logic            nm_memory_enable;
    logic            nm_memory_operation;
    logic            nm_memory_ready = 1'b0;
    logic [SB-1:0]   nm_memory_byte_mask;
    logic [WAS-1:0]  nm_memory_word_address;
    logic [SIZE-1:0] nm_memory_data_in = '0;
    logic [SIZE-1:0] nm_memory_data_out;
    logic            nm_mem_seen = 1'b0;

    always #5 clock = ~clock;

    memory_access_sequencer #(.SIZE(SIZE), .ALLOW_MISALIGNED(1'b1)) dut (
        .clock(clock), .reset(reset),
        .request_enable(request_enable), .request_operation(request_operation),
        .request_size(request_size), .request_signed(request_signed),
        .request_address(request_address), .request_data_out(request_data_out),
        .request_ready(request_ready), .request_error(request_error),
        .request_data_in(request_data_in),
        .memory_enable(memory_enable), .memory_operation(memory_operation),
        .memory_ready(memory_ready), .memory_byte_mask(memory_byte_mask),
        .memory_word_address(memory_word_address), .memory_data_in(memory_data_in),
        .memory_data_out(memory_data_out)
    );

    memory_access_sequencer #(.SIZE(SIZE), .ALLOW_MISALIGNED(1'b0)) dut_nm (
        .clock(clock), .reset(reset),
        .request_enable(nm_request_enable), .request_operation(request_operation),
        .request_size(request_size), .request_signed(request_signed),
        .request_address(request_address), .request_data_out(request_data_out),
        .request_ready(nm_request_ready), .request_error(nm_request_error),
        .request_data_in(nm_request_data_in),
        .memory_enable(nm_memory_enable), .memory_operation(nm_memory_operation),
        .memory_ready(nm_memory_ready), .memory_byte_mask(nm_memory_byte_mask),
        .memory_word_address(nm_memory_word_address), .memory_data_in(nm_memory_data_in),
        .memory_data_out(nm_memory_data_out)
    );

    always @(posedge clock) if (nm_memory_enable) nm_mem_seen <= 1'b1;

    typedef struct {
        logic [WAS-1:0] addr;
        logic [SB-1:0]  mask;
        logic           op;
        logic [31:0]    data;
    } txn_t;

    typedef struct {
        logic        op;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          ntx;
        logic [29:0] a0;
        logic [3:0]  m0;
        logic [31:0] d0;
        logic [29:0] a1;
        logic [3:0]  m1;
        logic [31:0] d1;
    } vec_t;

    txn_t txn_log[$];
    vec_t vecs[$];
    bit   hold_mem = 1'b0;
    int   wait_cnt = -1;
    int   n_checks = 0;
    int   n_pass = 0;

    function automatic logic [31:0] mem_word(input logic [WAS-1:0] a);
        case (a)
            30'h40:       return 32'h44332211;
            30'h41:       return 32'h88776655;
            30'h3FFFFFFF: return 32'hDDCCBBAA;
            30'h0:        return 32'h0F0E0D0C;
            default:      return 32'hDEADBEEF;
        endcase
    endfunction

    // Memory side: ready after 1-4 cycles, held until enable falls.
    initial begin : responder
        forever begin
            @(negedge clock);
            if (reset) begin
                memory_ready = 1'b0;
                wait_cnt = -1;
            end else if (memory_enable && !memory_ready && !hold_mem) begin
                if (wait_cnt < 0) wait_cnt = $urandom_range(0, 3);
                if (wait_cnt == 0) begin
                    memory_ready   = 1'b1;
                    memory_data_in = mem_word(memory_word_address);
                    txn_log.push_back('{memory_word_address, memory_byte_mask, memory_operation, memory_data_out});
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else if (!memory_enable && memory_ready) begin
                memory_ready   = 1'b0;
                memory_data_in = '0;
            end
        end
    end

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endtask

    task automatic do_req(input logic op, input logic [1:0] sz, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output bit ok);
        int cyc;
        txn_log.delete();
        @(negedge clock);
        request_operation = op;
        request_size      = sz;
        request_signed    = sgn;
        request_address   = addr;
        request_data_out  = wdata;
        request_enable    = 1'b1;
        cyc = 0;
        while (!request_ready && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        ok = request_ready;
        if (!ok) check("ready_timeout", {63'd0, request_ready}, 64'd1);
        rdata = request_data_in;
        err   = request_error;
        request_enable = 1'b0;
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (request_ready && cyc < 10);
        check("ready_release", {63'd0, request_ready}, 64'd0);
    endtask

    initial begin : main
        logic [31:0] rdata;
        logic        err;
        bit          ok;
        int          cyc;

        vecs.push_back('{OP_READ,  SIZE_WORD, 1'b0, 32'h100,      32'h0,        32'h44332211, 1'b0, 1, 30'h40,       4'hF, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_BYTE, 1'b1, 32'h103,      32'h0,        32'h00000044, 1'b0, 1, 30'h40,       4'h8, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_BYTE, 1'b1, 32'h107,      32'h0,        32'hFFFFFF88, 1'b0, 1, 30'h41,       4'h8, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_BYTE, 1'b0, 32'h107,      32'h0,        32'h00000088, 1'b0, 1, 30'h41,       4'h8, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_WORD, 1'b0, 32'h102,      32'h0,        32'h66554433, 1'b0, 2, 30'h40,       4'hC, 32'h0,        30'h41, 4'h3, 32'h0});
        vecs.push_back('{OP_WRITE, SIZE_HALF, 1'b0, 32'h103,      32'h0000BEEF, 32'h0,        1'b0, 2, 30'h40,       4'h8, 32'hEF000000, 30'h41, 4'h1, 32'h000000BE});
        vecs.push_back('{OP_READ,  SIZE_WORD, 1'b0, 32'hFFFFFFFE, 32'h0,        32'h0D0CDDCC, 1'b0, 2, 30'h3FFFFFFF, 4'hC, 32'h0,        30'h0,  4'h3, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_HALF, 1'b1, 32'h106,      32'h0,        32'hFFFF8877, 1'b0, 1, 30'h41,       4'hC, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_HALF, 1'b0, 32'h101,      32'h0,        32'h00003322, 1'b0, 1, 30'h40,       4'h6, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_HALF, 1'b1, 32'h103,      32'h0,        32'h00005544, 1'b0, 2, 30'h40,       4'h8, 32'h0,        30'h41, 4'h1, 32'h0});
        vecs.push_back('{OP_WRITE, SIZE_BYTE, 1'b0, 32'h102,      32'h000000A5, 32'h0,        1'b0, 1, 30'h40,       4'h4, 32'h00A50000, 30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_WRITE, SIZE_WORD, 1'b0, 32'h104,      32'hCAFEF00D, 32'h0,        1'b0, 1, 30'h41,       4'hF, 32'hCAFEF00D, 30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  2'd3,      1'b0, 32'h100,      32'h0,        32'h44332211, 1'b0, 1, 30'h40,       4'hF, 32'h0,        30'h0,  4'h0, 32'h0});
        vecs.push_back('{OP_READ,  SIZE_WORD, 1'b1, 32'h104,      32'h0,        32'h88776655, 1'b0, 1, 30'h41,       4'hF, 32'h0,        30'h0,  4'h0, 32'h0});

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_memory_enable", {63'd0, memory_enable}, 64'd0);
        check("rst_request_ready", {63'd0, request_ready}, 64'd0);
        check("rst_request_error", {63'd0, request_error}, 64'd0);
        check("rst_request_data_in", {32'd0, request_data_in}, 64'd0);
        check("rst_memory_lanes", {28'd0, memory_byte_mask, memory_word_address}, 64'd0);
        check("rst_memory_data_out", {31'd0, memory_operation, memory_data_out}, 64'd0);
        reset = 1'b0;

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            do_req(vecs[i].op, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata, rdata, err, ok);
            if (ok) begin
                check($sformatf("v%0d_ntx", i), 64'(txn_log.size()), 64'(vecs[i].ntx));
                check($sformatf("v%0d_err", i), {63'd0, err}, {63'd0, vecs[i].exp_err});
                if (vecs[i].op == OP_READ)
                    check($sformatf("v%0d_rdata", i), {32'd0, rdata}, {32'd0, vecs[i].exp_rdata});
                for (int k = 0; k < vecs[i].ntx && k < txn_log.size(); k++) begin
                    check($sformatf("v%0d_t%0d_addr", i, k), {34'd0, txn_log[k].addr}, {34'd0, (k == 0) ? vecs[i].a0 : vecs[i].a1});
                    check($sformatf("v%0d_t%0d_mask", i, k), {60'd0, txn_log[k].mask}, {60'd0, (k == 0) ? vecs[i].m0 : vecs[i].m1});
                    check($sformatf("v%0d_t%0d_op", i, k), {63'd0, txn_log[k].op}, {63'd0, vecs[i].op});
                    if (vecs[i].op == OP_WRITE)
                        check($sformatf("v%0d_t%0d_wdata", i, k), {32'd0, txn_log[k].data}, {32'd0, (k == 0) ? vecs[i].d0 : vecs[i].d1});
                end
            end
        end

        // Enable dropped early and inputs changed after acceptance: completes, ready pulses once.
        txn_log.delete();
        @(negedge clock);
        request_operation = OP_READ;
        request_size      = SIZE_WORD;
        request_signed    = 1'b0;
        request_address   = 32'h100;
        request_enable    = 1'b1;
        @(negedge clock);
        request_enable    = 1'b0;
        request_address   = 32'h107;
        request_size      = SIZE_BYTE;
        cyc = 0;
        while (!request_ready && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("early_drop_ready", {63'd0, request_ready}, 64'd1);
        check("early_drop_data", {32'd0, request_data_in}, 64'h44332211);
        @(negedge clock);
        check("early_drop_pulse", {63'd0, request_ready}, 64'd0);
        check("early_drop_ntx", 64'(txn_log.size()), 64'd1);

        // Misaligned rejection on the non-splitting instance
        @(negedge clock);
        request_operation = OP_READ;
        request_size      = SIZE_WORD;
        request_address   = 32'hFFFFFFFE;
        nm_request_enable = 1'b1;
        @(negedge clock);
        check("nm_ready_latency", {63'd0, nm_request_ready}, 64'd1);
        check("nm_error", {63'd0, nm_request_error}, 64'd1);
        nm_request_enable = 1'b0;
        @(negedge clock);
        check("nm_ready_release", {63'd0, nm_request_ready}, 64'd0);
        check("nm_no_memory_traffic", {63'd0, nm_mem_seen}, 64'd0);

        // Reset while waiting in FIRST_REQ
        hold_mem = 1'b1;
        @(negedge clock);
        request_operation = OP_READ;
        request_size      = SIZE_WORD;
        request_address   = 32'h100;
        request_enable    = 1'b1;
        @(negedge clock);
        check("mem_enable_latency", {63'd0, memory_enable}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_memory_enable", {63'd0, memory_enable}, 64'd0);
        check("rst_mid_request_ready", {63'd0, request_ready}, 64'd0);
        request_enable = 1'b0;
        @(negedge clock);
        reset    = 1'b0;
        hold_mem = 1'b0;
        do_req(OP_READ, SIZE_WORD, 1'b0, 32'h100, 32'h0, rdata, err, ok);
        if (ok) begin
            check("post_rst_rdata", {32'd0, rdata}, 64'h44332211);
            check("post_rst_ntx", 64'(txn_log.size()), 64'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
